// File: rtl/dm_responder.sv
// dm_responder: data-memory responder, one word access per request after WAIT_CYC wait states.
// Optional feature macro DM_PIPE_EN: accept the next request in the cycle the response handshakes.
module dm_responder #(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam bit         NO_WAIT   = (WAIT_CYC == 0);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  // Any set bit above the word index makes the access out of range (no wrap-around).
  function automatic logic addr_oor(input logic [31:0] addr);
    logic [31:0] hi;
    hi = addr >> (ADDR_W + 2);
    return (hi != 32'd0);
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return res;
  endfunction

  state_t              state_r;
  logic [3:0]          cnt_r;
  logic                cap_we_r;
  logic [31:0]         cap_addr_r;
  logic [31:0]         cap_wdata_r;
  logic [3:0]          cap_be_r;
  logic                req_ready_r;
  logic                rsp_valid_r;
  logic [31:0]         rsp_rdata_r;
  logic                rsp_err_r;
  logic [31:0]         mem_r [DEPTH];

  logic                req_ready_s;
  logic                accept_s;
  logic                rsp_hs_s;
  logic                acc_we_s;
  logic [31:0]         acc_addr_s;
  logic [31:0]         acc_wdata_s;
  logic [3:0]          acc_be_s;
  logic                acc_err_s;
  logic [ADDR_W-1:0]   acc_idx_s;
  logic [31:0]         rd_word_s;
  logic                do_access_s;
  logic                mem_we_s;

  // Request-ready: registered flag, or the response handshake when pipelined in RESP.
  always_comb begin
    req_ready_s = req_ready_r;
`ifdef DM_PIPE_EN
    if (state_r == ST_RESP) begin
      req_ready_s = rsp_ready;
    end else begin
      req_ready_s = req_ready_r;
    end
`endif
  end

  assign accept_s = req_valid && req_ready_s;
  assign rsp_hs_s = rsp_valid_r && rsp_ready;

  // Access fields: live inputs on a zero-wait accept, otherwise the captured request.
  always_comb begin
    if (accept_s) begin
      acc_we_s    = req_we;
      acc_addr_s  = req_addr;
      acc_wdata_s = req_wdata;
      acc_be_s    = req_be;
    end else begin
      acc_we_s    = cap_we_r;
      acc_addr_s  = cap_addr_r;
      acc_wdata_s = cap_wdata_r;
      acc_be_s    = cap_be_r;
    end
    acc_err_s = addr_oor(acc_addr_s);
    acc_idx_s = acc_addr_s[ADDR_W+1:2];
    if (acc_we_s || acc_err_s) begin
      rd_word_s = 32'd0;
    end else begin
      rd_word_s = mem_r[acc_idx_s];
    end
  end

  assign do_access_s = ((state_r == ST_WAIT) && (cnt_r == 4'd0)) || (accept_s && NO_WAIT);
  assign mem_we_s    = do_access_s && acc_we_s && !acc_err_s && !reset;

  // Byte-masked array write; the array itself is never cleared.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[acc_idx_s] <= merge_bytes(mem_r[acc_idx_s], acc_wdata_s, acc_be_s);
    end
  end

  // Transaction FSM with registered handshake and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'd0;
      rsp_err_r   <= 1'b0;
      cap_we_r    <= 1'b0;
      cap_addr_r  <= 32'd0;
      cap_wdata_r <= 32'd0;
      cap_be_r    <= 4'd0;
    end else if (accept_s) begin
      // Accept may come from IDLE or, when pipelined, from a handshaking RESP.
      cap_we_r    <= req_we;
      cap_addr_r  <= req_addr;
      cap_wdata_r <= req_wdata;
      cap_be_r    <= req_be;
      req_ready_r <= 1'b0;
      if (NO_WAIT) begin
        state_r     <= ST_RESP;
        rsp_valid_r <= 1'b1;
        rsp_rdata_r <= rd_word_s;
        rsp_err_r   <= acc_err_s;
      end else begin
        state_r     <= ST_WAIT;
        cnt_r       <= WAIT_INIT;
        rsp_valid_r <= 1'b0;
        rsp_rdata_r <= 32'd0;
        rsp_err_r   <= 1'b0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          req_ready_r <= 1'b1;
        end
        ST_WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r     <= ST_RESP;
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= rd_word_s;
            rsp_err_r   <= acc_err_s;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_hs_s) begin
            state_r     <= ST_IDLE;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          req_ready_r <= 1'b0;
          rsp_valid_r <= 1'b0;
          rsp_rdata_r <= 32'd0;
          rsp_err_r   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed stimulus against a transaction-level reference model of dm_responder.
module tb_dm_responder;

  localparam int          ADDR_W   = 10;
  localparam int          WAIT_CYC = 2;
  localparam logic [31:0] LIMIT    = 32'd1 << (ADDR_W + 2);

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int chk_total = 0;
  int chk_pass  = 0;

  dm_responder #(.ADDR_W(ADDR_W), .WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_total++;
    if (act === exp) chk_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check32(name, {31'd0, act}, {31'd0, exp});
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [int];
  logic        m_ready, m_valid, m_err;
  logic [31:0] m_rdata;
  int          m_left;
  logic        p_we;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_be;

  task automatic model_complete();
    int          idx;
    logic [31:0] w;
    m_valid = 1'b1;
    m_rdata = 32'd0;
    m_err   = (p_addr >= LIMIT);
    idx     = int'(p_addr >> 2);
    if (!m_err && p_we) begin
      w = ref_mem.exists(idx) ? ref_mem[idx] : 32'd0;
      for (int b = 0; b < 4; b++) if (p_be[b]) w[8*b +: 8] = p_wdata[8*b +: 8];
      ref_mem[idx] = w;
    end else if (!m_err) begin
      m_rdata = ref_mem.exists(idx) ? ref_mem[idx] : 32'hxxxx_xxxx;
    end
  endtask

  task automatic model_step();
    logic ready_eff, acc, hs;
    if (reset) begin
      m_ready = 1'b0; m_valid = 1'b0; m_rdata = 32'd0; m_err = 1'b0; m_left = 0;
    end else begin
      ready_eff = m_ready;
`ifdef DM_PIPE_EN
      if (m_valid) ready_eff = rsp_ready;
`endif
      acc = req_valid && ready_eff;
      hs  = m_valid && rsp_ready;
      if (hs) begin
        m_valid = 1'b0; m_rdata = 32'd0; m_err = 1'b0; m_ready = 1'b1;
      end
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) model_complete();
      end
      if (acc) begin
        p_we = req_we; p_addr = req_addr; p_wdata = req_wdata; p_be = req_be;
        m_ready = 1'b0;
        if (WAIT_CYC == 0) model_complete();
        else m_left = WAIT_CYC;
      end else if (!m_valid && m_left == 0) begin
        m_ready = 1'b1;
      end
    end
  endtask

  initial begin
    m_ready = 1'b0; m_valid = 1'b0; m_rdata = 32'd0; m_err = 1'b0; m_left = 0;
    forever begin
      @(posedge clk or posedge reset);
      model_step();
    end
  end

  // Compare DUT outputs with the model on every falling edge.
  always @(negedge clk) begin
    logic exp_rr;
    exp_rr = m_ready;
`ifdef DM_PIPE_EN
    if (m_valid) exp_rr = rsp_ready;
`endif
    check1("mon_req_ready", req_ready, exp_rr);
    check1("mon_rsp_valid", rsp_valid, m_valid);
    if (m_valid || reset) begin
      check32("mon_rsp_rdata", rsp_rdata, m_rdata);
      check1("mon_rsp_err", rsp_err, m_err);
    end
  end

  // ---------------- stimulus ----------------
  // Called at posedge+1; returns at posedge+1 after the response handshake.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int hold,
                     output logic [31:0] rd, output logic er, output int lat);
    int guard;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    rsp_ready = (hold == 0);
    rd = 32'd0; er = 1'b0; lat = 0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!req_ready && guard < 20);
    if (!req_ready) check1("accept_timeout", req_ready, 1'b1);
    @(posedge clk);
    #1;
    // Scramble the inputs: the captured request must be used.
    req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFFF; req_wdata = ~wdata; req_be = ~be;
    lat = 1;
    guard = 0;
    @(negedge clk);
    while (!rsp_valid && guard < 20) begin
      lat++; guard++;
      @(negedge clk);
    end
    if (!rsp_valid) check1("rsp_timeout", rsp_valid, 1'b1);
    rd = rsp_rdata;
    er = rsp_err;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check1("bp_valid", rsp_valid, 1'b1);
      check32("bp_rdata", rsp_rdata, rd);
      check1("bp_err", rsp_err, er);
      check1("bp_req_ready", req_ready, 1'b0);
    end
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          cyc, acc_n, rsp_n, guard;
    logic        started, a, h;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
    req_wdata = 32'd0; req_be = 4'd0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
    check1("idle_ready", req_ready, 1'b1);

    // Reset mid-idle: outputs drop at once, ready returns one edge after release.
    #1 reset = 1'b1;
    #1;
    check1("rst_req_ready", req_ready, 1'b0);
    check1("rst_rsp_valid", rsp_valid, 1'b0);
    check32("rst_rsp_rdata", rsp_rdata, 32'd0);
    check1("rst_rsp_err", rsp_err, 1'b0);
    @(posedge clk);
    #3 reset = 1'b0;
    @(negedge clk);
    check1("ready_before_edge", req_ready, 1'b0);
    @(posedge clk);
    #1;
    check1("ready_after_edge", req_ready, 1'b1);

    // Write then read with latency.
    txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, rd, er, lat);
    check32("wr_rdata", rd, 32'd0);
    check1("wr_err", er, 1'b0);
    check32("wr_latency", lat, 32'd3);
    txn(1'b0, 32'h0000_0010, 32'd0, 4'h0, 0, rd, er, lat);
    check32("rd_deadbeef", rd, 32'hDEAD_BEEF);
    check1("rd_err", er, 1'b0);
    check32("rd_latency", lat, 32'd3);

    // Byte enables.
    txn(1'b1, 32'h0000_0010, 32'h1122_3344, 4'b0101, 0, rd, er, lat);
    txn(1'b0, 32'h0000_0013, 32'd0, 4'hF, 0, rd, er, lat);
    check32("rd_be_merge", rd, 32'hDE22_BE44);

    // be=0 write is a legal no-op.
    txn(1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, 0, rd, er, lat);
    check1("be0_err", er, 1'b0);
    txn(1'b0, 32'h0000_0010, 32'd0, 4'h0, 0, rd, er, lat);
    check32("rd_after_be0", rd, 32'hDE22_BE44);

    // Last legal word, then first illegal word and a high-bit address.
    txn(1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 4'hF, 0, rd, er, lat);
    txn(1'b1, 32'h0000_1000, 32'h0000_0055, 4'hF, 0, rd, er, lat);
    check1("oor_wr_err", er, 1'b1);
    check32("oor_wr_rdata", rd, 32'd0);
    txn(1'b0, 32'h0000_0FFC, 32'd0, 4'h0, 0, rd, er, lat);
    check32("rd_last_word", rd, 32'hCAFE_F00D);
    check1("rd_last_err", er, 1'b0);
    txn(1'b0, 32'h8000_0010, 32'd0, 4'h0, 0, rd, er, lat);
    check1("oor_rd_err", er, 1'b1);
    check32("oor_rd_rdata", rd, 32'd0);
    txn(1'b0, 32'h0000_0000, 32'd0, 4'h0, 0, rd, er, lat);
    txn(1'b0, 32'h0000_0010, 32'd0, 4'h0, 0, rd, er, lat);
    check32("rd_no_wrap", rd, 32'hDE22_BE44);

    // Response backpressure for 5 extra cycles.
    txn(1'b0, 32'h0000_0010, 32'd0, 4'h0, 5, rd, er, lat);
    check32("bp_final_rdata", rd, 32'hDE22_BE44);

    // Reset while a write is waiting: the write is discarded.
    txn(1'b1, 32'h0000_0020, 32'h0000_0000, 4'hF, 0, rd, er, lat);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0020;
    req_wdata = 32'hA5A5_A5A5; req_be = 4'hF;
    @(negedge clk);
    check1("wait_accept", req_ready, 1'b1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    txn(1'b0, 32'h0000_0020, 32'd0, 4'h0, 0, rd, er, lat);
    check32("rd_after_wait_reset", rd, 32'h0000_0000);

`ifdef DM_PIPE_EN
    // Pipelined burst of 4 reads with rsp_ready held high.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0010; rsp_ready = 1'b1;
    acc_n = 0; rsp_n = 0; cyc = 0; started = 1'b0; guard = 0;
    while (rsp_n < 4 && guard < 100) begin
      @(negedge clk);
      a = req_valid && req_ready;
      h = rsp_valid && rsp_ready;
      @(posedge clk);
      #1;
      if (started) cyc++;
      if (a) begin
        acc_n++;
        started = 1'b1;
        if (acc_n == 4) req_valid = 1'b0;
      end
      if (h) rsp_n++;
      guard++;
    end
    check32("pipe_burst_cycles", cyc, 32'd12);
`else
    cyc = 0; acc_n = 0; rsp_n = 0; guard = 0; started = 1'b0; a = 1'b0; h = 1'b0;
`endif

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
